// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny hysteresis stage.
package canny_pkg;

  localparam int MAG_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_WEAK   = 2'd1,
    CLS_STRONG = 2'd2
  } cls_e;

  localparam logic [7:0] EDGE_ON  = 8'hFF;
  localparam logic [7:0] EDGE_OFF = 8'h00;

endpackage

// File: rtl/canny_cls_linebuf.sv
// Two-row class line buffer: returns the classes of the previous two rows at
// the current column and ages that column by one row on each accepted write.
module canny_cls_linebuf
  import canny_pkg::*;
#(
  parameter  int IMAGE_WIDTH = 320,
  localparam int AW          = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   row_i,
  input  cls_e          cls_i,
  output cls_e          up1_o,
  output cls_e          up2_o
);

  // Storage is never reset; the row masking below hides stale frames.
  cls_e lb0_q [IMAGE_WIDTH];
  cls_e lb1_q [IMAGE_WIDTH];

  // Read both previous rows, masking rows that lie above the frame top
  always_comb begin
    up1_o = lb0_q[addr_i];
    up2_o = lb1_q[addr_i];
    if (row_i < 32'd1) up1_o = CLS_NONE;
    if (row_i < 32'd2) up2_o = CLS_NONE;
  end

  // Age the addressed column by one row and store the new class
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      lb1_q[addr_i] <= lb0_q[addr_i];
      lb0_q[addr_i] <= cls_i;
    end
  end

endmodule

// File: rtl/canny_hysteresis.sv
// Double-threshold hysteresis: classify magnitudes, build a 3x3 class window
// and emit a binary edge stream for the window centre with a frame edge count.
// The pixel output is named edge_o because "edge" is a reserved word.
module canny_hysteresis
  import canny_pkg::*;
#(
  parameter int IMAGE_WIDTH = 320,
  parameter int MAG_W       = MAG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nms_valid,
  input  logic [MAG_W-1:0] nms_mag,
  input  logic [31:0]      center_row,
  input  logic [31:0]      center_col,
  input  logic [MAG_W-1:0] low_thr,
  input  logic [MAG_W-1:0] high_thr,
  output logic             edge_valid,
  output logic [7:0]       edge_o,
  output logic [31:0]      edge_row,
  output logic [31:0]      edge_col,
  output logic [31:0]      edge_count
);

  localparam int AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

  // With low_thr > high_thr, any mag >= low_thr is already STRONG, so WEAK
  // can only appear when the thresholds are ordered.
  function automatic cls_e classify(input logic [MAG_W-1:0] mag,
                                    input logic [MAG_W-1:0] lo,
                                    input logic [MAG_W-1:0] hi);
    if (mag >= hi) return CLS_STRONG;
    if (mag >= lo && mag != '0) return CLS_WEAK;
    return CLS_NONE;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic        vld_p1_q;
  cls_e        cls_p1_q;
  logic [31:0] row_p1_q, col_p1_q;
  logic        acc_p1;
  cls_e        up1_p1, up2_p1;
  logic        vld_p2_q;
  logic [31:0] row_p2_q, col_p2_q;
  cls_e        win_q [3][3];
  cls_e        win_d [3][3];
  logic        strong_nb, is_edge, emit_p2, frame_start;
  logic [31:0] count_d;

  // ---- S1: classify ----
  // Sample valid into S1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= nms_valid;
  end

  // Class and coordinates into S1
  always_ff @(posedge clk) begin
    if (nms_valid) begin
      cls_p1_q <= classify(nms_mag, low_thr, high_thr);
      row_p1_q <= center_row;
      col_p1_q <= center_col;
    end
  end

  // ---- S2: line buffers and window ----
  assign acc_p1 = vld_p1_q && (col_p1_q < 32'(IMAGE_WIDTH));

  canny_cls_linebuf #(.IMAGE_WIDTH(IMAGE_WIDTH)) u_linebuf (
    .clk     (clk),
    .wr_en_i (acc_p1),
    .addr_i  (col_p1_q[AW-1:0]),
    .row_i   (row_p1_q),
    .cls_i   (cls_p1_q),
    .up1_o   (up1_p1),
    .up2_o   (up2_p1)
  );

  // Shift the window left; a column-0 sample starts from an empty window
  always_comb begin
    win_d = win_q;
    if (acc_p1) begin
      for (int r = 0; r < 3; r++) begin
        win_d[0][r] = (col_p1_q == 32'd0) ? CLS_NONE : win_q[1][r];
        win_d[1][r] = (col_p1_q == 32'd0) ? CLS_NONE : win_q[2][r];
      end
      win_d[2][0] = up2_p1;
      win_d[2][1] = up1_p1;
      win_d[2][2] = cls_p1_q;
    end
  end

  // Window registers and S2 valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          win_q[c][r] <= CLS_NONE;
    end else begin
      vld_p2_q <= acc_p1;
      win_q    <= win_d;
    end
  end

  // Coordinates of the newest window column
  always_ff @(posedge clk) begin
    if (acc_p1) begin
      row_p2_q <= row_p1_q;
      col_p2_q <= col_p1_q;
    end
  end

  // ---- S3: decide and emit ----
  // Single-pass hysteresis on the window centre
  always_comb begin
    strong_nb = 1'b0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        if ((c != 1 || r != 1) && win_q[c][r] == CLS_STRONG) strong_nb = 1'b1;
    is_edge = (win_q[1][1] == CLS_STRONG) ||
              (win_q[1][1] == CLS_WEAK && strong_nb);
    emit_p2 = vld_p2_q && (row_p2_q >= 32'd1) && (col_p2_q >= 32'd1);
  end

  // Frame clear takes priority over a coincident increment
  always_comb begin
    frame_start = nms_valid && (center_row == 32'd0) && (center_col == 32'd0);
    count_d     = edge_count;
    if (frame_start)            count_d = 32'd0;
    else if (emit_p2 && is_edge) count_d = sat_inc(edge_count);
  end

  // Output pixel, coordinates and edge count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_valid <= 1'b0;
      edge_o     <= EDGE_OFF;
      edge_row   <= 32'd0;
      edge_col   <= 32'd0;
      edge_count <= 32'd0;
    end else begin
      edge_valid <= emit_p2;
      if (emit_p2) begin
        edge_o   <= is_edge ? EDGE_ON : EDGE_OFF;
        edge_row <= row_p2_q - 32'd1;
        edge_col <= col_p2_q - 32'd1;
      end
      edge_count <= count_d;
    end
  end

endmodule

// File: doc/canny_hysteresis.md
# canny_hysteresis

Double-threshold hysteresis stage of the Canny pipeline. It sits directly downstream of the non-maximum-suppression stage and consumes its `nms_valid` / `nms_mag` / `center_row` / `center_col` stream. Each magnitude is classified as strong, weak or none, and a 3x3 class window is built from two line buffers. The block emits a binary edge pixel stream (0/255) with coordinates and a per-frame edge count.

## Interface
- `IMAGE_WIDTH`, 320: pixels per row; column index range 0..IMAGE_WIDTH-1.
- `MAG_W`, 12: magnitude and threshold width.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `nms_valid`  in  1  input sample strobe.
- `nms_mag`  in  MAG_W  suppressed gradient magnitude.
- `center_row`  in  32  row of the sample.
- `center_col`  in  32  column of the sample.
- `low_thr`  in  MAG_W  weak threshold; quasi-static, sampled with each valid sample.
- `high_thr`  in  MAG_W  strong threshold; quasi-static.
- `edge_valid`  out  1  output pixel strobe, one cycle per pixel.
- `edge`  out  8  8'hFF edge, 8'h00 non-edge.
- `edge_row`  out  32  row of the output pixel.
- `edge_col`  out  32  column of the output pixel.
- `edge_count`  out  32  number of 8'hFF pixels emitted in the current frame.

## Operation
- **Classify (S1).** Performed on each cycle with `nms_valid`=1.
  - cls = STRONG if `nms_mag` >= `high_thr`.
  - Else cls = WEAK if `nms_mag` >= `low_thr` and `nms_mag` != 0.
  - Else cls = NONE.
  - If `low_thr` > `high_thr`, WEAK is never produced.
  - cls, row and col are registered.
- **Window (S2).** Acts on each S1-valid sample.
  - Samples with col >= IMAGE_WIDTH are dropped: no buffer write and no output.
  - Read lb0[col] (previous row) and lb1[col] (two rows back).
  - Write lb1[col] <= lb0[col] and lb0[col] <= cls.
  - Shift the 3-column window left. The new right column is {lb1, lb0, cls}, top to bottom.
  - Row forcing: the lb1 read is forced to NONE when row < 2. The lb0 read is forced to NONE when row < 1. Line buffers are not reset; these forcing rules hide stale data from a previous frame.
  - Column 0: the two left window columns are cleared to NONE before shifting, so nothing wraps across rows.
- **Decide (S3).** Applies to the window centre, located at (row-1, col-1).
  - `edge` = 8'hFF if the centre is STRONG.
  - `edge` = 8'hFF if the centre is WEAK and any of its 8 neighbours is STRONG.
  - Otherwise `edge` = 8'h00.
  - This is single-pass hysteresis; there is no iterative propagation.
- **Emission.**
  - `edge_valid`=1 only when row >= 1 and col >= 1, with `edge_row`=row-1 and `edge_col`=col-1.
  - Column IMAGE_WIDTH-1 and the last image row are never emitted as a centre.
- **Edge count.**
  - `edge_count` is cleared to 0 when a sample with row=0, col=0 reaches S1.
  - It increments by 1 on each emitted 8'hFF. When the clear and an increment coincide, the clear wins and the increment is dropped.
  - It saturates at 32'hFFFFFFFF.

## Timing
- Latency is 3 cycles. A sample accepted at edge t reaches S1 at t+1 and S2 at t+2. Its output (centre = previous column) is registered at t+3.
- Input gaps propagate as gaps; `edge_valid` is never asserted without a matching input sample.
- Back-to-back samples are accepted every cycle, with no backpressure.
- Reset values: `edge_valid`=0, `edge`=0, `edge_row`=0, `edge_col`=0, `edge_count`=0. All pipeline valids and window registers are also 0.
- Reset mid-frame: in-flight samples are discarded with no output. Processing restarts cleanly at the next row-0 input.
- Threshold changes take effect from the next sample entering S1. Samples already in the pipeline keep their classification.

## Structure
- Shared package `canny_pkg`:
  - `CLS_NONE`=2'd0, `CLS_WEAK`=2'd1, `CLS_STRONG`=2'd2.
  - `EDGE_ON`=8'hFF, `EDGE_OFF`=8'h00.
  - `MAG_W` default.
- Sub-module `canny_cls_linebuf`:
  - Dual 2-bit x IMAGE_WIDTH line buffer.
  - Read-before-write at one address per cycle.
  - Outputs the two previous-row classes and applies the row forcing.
- The top level holds S1, the window registers, the decision logic, the emission logic and the counter.

## Test plan
All scenarios use IMAGE_WIDTH=8, `low_thr`=50 and `high_thr`=100.
- **Reset.** Assert `rst` asynchronously between clock edges -> all outputs are 0 immediately. After release, the first emitted pixel is (0,0) once row 1 / col 1 is fed.
- **Isolated strong pixel.** One pixel of magnitude 150 at (3,4), all other pixels 0 -> exactly one 8'hFF, at `edge_row`=3 / `edge_col`=4. It appears 3 cycles after the sample at (4,5). `edge_count`=1 at end of frame.
- **Weak pixels.**
  - Weak 70 at (3,4) with strong 120 at (2,5) -> (3,4) and (2,5) are both 8'hFF.
  - Weak 70 with no strong neighbour -> 8'h00.
  - A weak pixel whose only strong pixel sits 2 columns away -> 8'h00.
- **Row-boundary wrap.** Strong pixel at (2,7), weak pixel at (3,0) -> (3,0) is not promoted, because the window is cleared at col 0.
- **Frame restart.** Frame A has every pixel at 200. Frame B has every pixel at 0 -> B emits all 8'h00, with no stale strong pixels from A in B's row 0 or row 1. `edge_count` restarts at 0 when B's (0,0) sample arrives.
- **Throughput.** A continuous valid stream and a stream with random 50% gaps must produce identical `edge` sequences. Every output must have a corresponding input exactly 3 cycles earlier.
